// File: rtl/sync_8b10b_pkg.sv
// Shared types and helpers for the 8b/10b receive link synchroniser.
package sync_8b10b_pkg;

  // Decoded K28.5 comma byte.
  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    StLoss   = 2'd0,
    StAcq    = 2'd1,
    StSynced = 2'd2
  } link_state_e;

  // A comma is a clean, valid K word carrying the comma byte; a violated comma is not a comma.
  function automatic logic is_comma(input logic       dv,
                                    input logic       k,
                                    input logic [7:0] d,
                                    input logic       viol,
                                    input logic [7:0] comma);
    return dv & k & (d == comma) & ~viol;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority; increment stops at the all-ones ceiling.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/link_sync_8b10b.sv
// Comma-based link acquire/lose controller sitting after the 8b/10b decoder.
// Requests bit-slips while unsynchronised and forwards decoded words only while in sync.
module link_sync_8b10b
  import sync_8b10b_pkg::*;
#(
  parameter int unsigned ACQ_COMMAS   = 3,
  parameter int unsigned LOSS_VIOLS   = 4,
  parameter int unsigned GOOD_RUN     = 4,
  parameter int unsigned SLIP_TIMEOUT = 64,
  parameter logic [7:0]  COMMA        = K28_5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DVI,
  input  logic        KI,
  input  logic [7:0]  DI,
  input  logic        VIOLI,
  output logic        SLIP,
  output logic        SYNC,
  output logic        DVO,
  output logic        K,
  output logic [7:0]  DO,
  output logic        VIOL,
  output logic [15:0] ERR_CNT
);

  localparam int unsigned CW = $clog2(ACQ_COMMAS + 1);
  localparam int unsigned TW = $clog2(SLIP_TIMEOUT + 1);
  localparam int unsigned BW = $clog2(LOSS_VIOLS + 1);
  localparam int unsigned GW = $clog2(GOOD_RUN + 1);

  // Terminal values: the event fires when the counter is one short and another word arrives.
  localparam logic [CW-1:0] ACQ_LAST  = CW'(ACQ_COMMAS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(SLIP_TIMEOUT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_VIOLS - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_RUN - 1);

  link_state_e   r_state, w_state_d;
  logic [CW-1:0] r_comma_cnt, w_comma_d;
  logic [TW-1:0] r_tmo_cnt, w_tmo_d;
  logic [BW-1:0] r_bad_cnt, w_bad_d;
  logic [GW-1:0] r_good_cnt, w_good_d;
  logic          r_slip, w_slip_d;
  logic          r_dvo;
  logic          r_k;
  logic [7:0]    r_do;
  logic          r_viol;
  logic          w_comma;
  logic          w_err_inc;

  assign w_comma = is_comma(DVI, KI, DI, VIOLI, COMMA);

  // Next-state and counter update; nothing moves on DVI=0 cycles except the SLIP pulse ending.
  always_comb begin
    w_state_d = r_state;
    w_comma_d = r_comma_cnt;
    w_tmo_d   = r_tmo_cnt;
    w_bad_d   = r_bad_cnt;
    w_good_d  = r_good_cnt;
    w_slip_d  = 1'b0;
    w_err_inc = 1'b0;

    if (DVI) begin
      case (r_state)
        StLoss: begin
          if (w_comma) begin
            w_tmo_d = '0;
            if (ACQ_COMMAS <= 1) begin
              w_state_d = StSynced;
              w_comma_d = '0;
              w_bad_d   = '0;
              w_good_d  = '0;
            end else begin
              w_state_d = StAcq;
              w_comma_d = CW'(1);
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            w_slip_d = 1'b1;
            w_tmo_d  = '0;
          end else begin
            w_tmo_d = r_tmo_cnt + 1'b1;
          end
        end

        StAcq: begin
          if (VIOLI) begin
            w_state_d = StLoss;
            w_comma_d = '0;
            w_tmo_d   = '0;
            w_bad_d   = '0;
            w_good_d  = '0;
          end else if (w_comma) begin
            if (r_comma_cnt == ACQ_LAST) begin
              w_state_d = StSynced;
              w_comma_d = '0;
              w_bad_d   = '0;
              w_good_d  = '0;
            end else begin
              w_comma_d = r_comma_cnt + 1'b1;
            end
          end
        end

        StSynced: begin
          if (VIOLI) begin
            w_err_inc = 1'b1;
            w_good_d  = '0;
            if (r_bad_cnt == BAD_LAST) begin
              w_state_d = StLoss;
              w_comma_d = '0;
              w_tmo_d   = '0;
              w_bad_d   = '0;
            end else begin
              w_bad_d = r_bad_cnt + 1'b1;
            end
          end else if (r_good_cnt == GOOD_LAST) begin
            // A full clean run forgives one violation.
            w_good_d = '0;
            if (r_bad_cnt != '0) begin
              w_bad_d = r_bad_cnt - 1'b1;
            end
          end else begin
            w_good_d = r_good_cnt + 1'b1;
          end
        end

        default: begin
          w_state_d = StLoss;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StLoss;
      r_comma_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_bad_cnt   <= '0;
      r_good_cnt  <= '0;
      r_slip      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_comma_cnt <= w_comma_d;
      r_tmo_cnt   <= w_tmo_d;
      r_bad_cnt   <= w_bad_d;
      r_good_cnt  <= w_good_d;
      r_slip      <= w_slip_d;
    end
  end

  // Forwarding registers; valid only for words seen while already in sync.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dvo  <= 1'b0;
      r_k    <= 1'b0;
      r_do   <= 8'h00;
      r_viol <= 1'b0;
    end else begin
      r_dvo <= DVI & (r_state == StSynced);
      if (DVI) begin
        r_k    <= KI;
        r_do   <= DI;
        r_viol <= VIOLI;
      end
    end
  end

  sat_counter #(
    .WIDTH (16)
  ) u_err_cnt (
    .i_clk   (CLK),
    .i_clr   (RST),
    .i_inc   (w_err_inc),
    .o_count (ERR_CNT)
  );

  assign SLIP = r_slip;
  assign SYNC = (r_state == StSynced);
  assign DVO  = r_dvo;
  assign K    = r_k;
  assign DO   = r_do;
  assign VIOL = r_viol;

endmodule

// File: tb/tb_link_sync_8b10b.sv
// Self-checking bench for link_sync_8b10b: vector table, directed corner sequences,
// randomized traffic against a behavioural model, and a saturation run on a second instance.
module tb_link_sync_8b10b;

  localparam int ACQ  = 3;
  localparam int LOSS = 4;
  localparam int GOOD = 4;
  localparam int TMO  = 64;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        dvi = 1'b0;
  logic        ki = 1'b0;
  logic [7:0]  di = 8'h00;
  logic        violi = 1'b0;
  logic        slip, sync, dvo, k_o, viol_o;
  logic [7:0]  do_o;
  logic [15:0] err_cnt;

  // Second instance used only for the ERR_CNT saturation run.
  logic        s_rst = 1'b1;
  logic        s_dvi = 1'b0;
  logic        s_ki = 1'b0;
  logic [7:0]  s_di = 8'h00;
  logic        s_violi = 1'b0;
  logic        s_slip, s_sync, s_dvo, s_k, s_viol;
  logic [7:0]  s_do;
  logic [15:0] s_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  link_sync_8b10b #(
    .ACQ_COMMAS   (ACQ),
    .LOSS_VIOLS   (LOSS),
    .GOOD_RUN     (GOOD),
    .SLIP_TIMEOUT (TMO),
    .COMMA        (8'hBC)
  ) dut (
    .CLK     (CLK),
    .RST     (rst),
    .DVI     (dvi),
    .KI      (ki),
    .DI      (di),
    .VIOLI   (violi),
    .SLIP    (slip),
    .SYNC    (sync),
    .DVO     (dvo),
    .K       (k_o),
    .DO      (do_o),
    .VIOL    (viol_o),
    .ERR_CNT (err_cnt)
  );

  link_sync_8b10b #(
    .ACQ_COMMAS   (2),
    .LOSS_VIOLS   (1000),
    .GOOD_RUN     (4),
    .SLIP_TIMEOUT (64),
    .COMMA        (8'hBC)
  ) dut_sat (
    .CLK     (CLK),
    .RST     (s_rst),
    .DVI     (s_dvi),
    .KI      (s_ki),
    .DI      (s_di),
    .VIOLI   (s_violi),
    .SLIP    (s_slip),
    .SYNC    (s_sync),
    .DVO     (s_dvo),
    .K       (s_k),
    .DO      (s_do),
    .VIOL    (s_viol),
    .ERR_CNT (s_err)
  );

  // ---------------- behavioural model ----------------
  // Acquisition is "some commas seen but not yet in sync"; loss is "no commas, not in sync".
  bit       m_sync;
  int       m_commas, m_since, m_bad, m_good, m_err;
  bit       m_slip, m_dvo, m_k, m_viol;
  bit [7:0] m_do;

  task automatic model_reset();
    m_sync = 0; m_commas = 0; m_since = 0; m_bad = 0; m_good = 0; m_err = 0;
    m_slip = 0; m_dvo = 0; m_k = 0; m_viol = 0; m_do = 8'h00;
  endtask

  task automatic model_step(input bit r, input bit v, input bit kk, input bit [7:0] d,
                            input bit vi);
    bit is_c;
    is_c = v && kk && (d == 8'hBC) && !vi;
    m_slip = 0;
    if (r) begin
      model_reset();
      return;
    end
    m_dvo = v && m_sync;
    if (!v) return;
    m_k = kk; m_do = d; m_viol = vi;
    if (m_sync) begin
      if (vi) begin
        if (m_err < 65535) m_err++;
        m_bad++;
        m_good = 0;
        if (m_bad >= LOSS) begin
          m_sync = 0; m_bad = 0; m_commas = 0; m_since = 0;
        end
      end else begin
        m_good++;
        if (m_good == GOOD) begin
          if (m_bad > 0) m_bad--;
          m_good = 0;
        end
      end
    end else if (m_commas > 0) begin
      if (vi) m_commas = 0;
      else if (is_c) begin
        m_commas++;
        if (m_commas == ACQ) begin
          m_sync = 1; m_commas = 0; m_bad = 0; m_good = 0;
        end
      end
    end else begin
      if (is_c) begin
        m_commas = 1; m_since = 0;
      end else begin
        m_since++;
        if (m_since == TMO) begin
          m_slip = 1; m_since = 0;
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic kk, input logic [7:0] d,
                      input logic vi);
    rst = r; dvi = v; ki = kk; di = d; violi = vi;
    @(posedge CLK);
    model_step(r, v, kk, d, vi);
    #1;
  endtask

  task automatic comma();
    step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b0);
  endtask

  task automatic data(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic bad(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, d, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic reset_acquire();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    comma(); comma(); comma();
  endtask

  task automatic s_step(input logic r, input logic v, input logic kk, input logic [7:0] d,
                        input logic vi);
    s_rst = r; s_dvi = v; s_ki = kk; s_di = d; s_violi = vi;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic       dvi;
    logic       ki;
    logic [7:0] di;
    logic       violi;
    logic       e_sync;
    logic       e_dvo;
    logic [7:0] e_do;
    logic       e_viol;
    logic [15:0] e_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int slips;
    int sent;
    logic [7:0] dd;
    logic kk, dv, vi, rr;
    int r;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b0, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 8'hBC, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 16'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 1'b1, 8'hBC, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 16'd1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};

    model_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_slip", {31'd0, slip}, 32'd0);
    check("reset_k", {31'd0, k_o}, 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].dvi, tbl[i].ki, tbl[i].di, tbl[i].violi);
      check($sformatf("tbl%0d_sync", i), {31'd0, sync}, {31'd0, tbl[i].e_sync});
      check($sformatf("tbl%0d_dvo", i), {31'd0, dvo}, {31'd0, tbl[i].e_dvo});
      check($sformatf("tbl%0d_do", i), {24'd0, do_o}, {24'd0, tbl[i].e_do});
      check($sformatf("tbl%0d_viol", i), {31'd0, viol_o}, {31'd0, tbl[i].e_viol});
      check($sformatf("tbl%0d_err", i), {16'd0, err_cnt}, {16'd0, tbl[i].e_err});
    end

    // SLIP timeout: 63 words give none, the 64th gives one; the next needs 64 more.
    for (int pass = 0; pass < 2; pass++) begin
      slips = 0;
      for (int i = 1; i <= TMO; i++) begin
        data(8'h11);
        if (i < TMO) slips += int'(slip);
        if (pass == 1 && i == 20) begin
          idle();
          slips += int'(slip);
        end
      end
      check($sformatf("slip_quiet%0d", pass), slips, 32'd0);
      check($sformatf("slip_pulse%0d", pass), {31'd0, slip}, 32'd1);
      idle();
      check($sformatf("slip_width%0d", pass), {31'd0, slip}, 32'd0);
    end

    // Violated comma in ACQ restarts acquisition.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    comma(); comma();
    step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b1);
    check("acqviol_sync", {31'd0, sync}, 32'd0);
    check("acqviol_fwd_viol", {31'd0, viol_o}, 32'd1);
    check("acqviol_dvo", {31'd0, dvo}, 32'd0);
    comma(); comma();
    check("acqviol_restart2", {31'd0, sync}, 32'd0);
    comma();
    check("acqviol_restart3", {31'd0, sync}, 32'd1);

    // Four violations separated by three clean words lose sync.
    reset_acquire();
    for (int v = 0; v < 4; v++) begin
      if (v == 3) check("drop_before4", {31'd0, sync}, 32'd1);
      bad(8'h40 + 8'(v));
      if (v < 3) begin
        data(8'h01); data(8'h02); data(8'h03);
      end
    end
    check("drop_sync", {31'd0, sync}, 32'd0);
    check("drop_err", {16'd0, err_cnt}, 32'd4);
    check("drop_fwd", {30'd0, dvo, viol_o}, 32'd3);
    check("drop_do", {24'd0, do_o}, 32'h43);

    // Four clean words between violations forgive each one.
    reset_acquire();
    for (int v = 0; v < 6; v++) begin
      bad(8'h50);
      data(8'h01); data(8'h02); data(8'h03); data(8'h04);
    end
    check("forgive_sync", {31'd0, sync}, 32'd1);
    check("forgive_err", {16'd0, err_cnt}, 32'd6);

    // Boundary: bad=3, good=3; a clean word decrements, then two violations are needed.
    reset_acquire();
    bad(8'h60); bad(8'h61); bad(8'h62);
    data(8'h01); data(8'h02); data(8'h03); data(8'h04);
    bad(8'h63);
    check("edge_keep", {31'd0, sync}, 32'd1);
    bad(8'h64);
    check("edge_drop", {31'd0, sync}, 32'd0);

    // DVI gaps during acquisition change nothing.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    comma();
    for (int i = 0; i < 10; i++) idle();
    check("gap_hold_do", {24'd0, do_o}, 32'hBC);
    comma();
    for (int i = 0; i < 10; i++) idle();
    check("gap_sync_pre", {31'd0, sync}, 32'd0);
    comma();
    check("gap_sync", {31'd0, sync}, 32'd1);
    data(8'h5A);
    check("gap_dvo", {31'd0, dvo}, 32'd1);
    for (int i = 0; i < 10; i++) idle();
    check("gap_hold_5a", {24'd0, do_o}, 32'h5A);
    check("gap_dvo_low", {31'd0, dvo}, 32'd0);

    // RST mid-sync clears every output at the next edge.
    bad(8'h77);
    step(1'b1, 1'b1, 1'b1, 8'hBC, 1'b1);
    check("rstsync_outs", {2'd0, slip, sync, dvo, k_o, do_o, viol_o, err_cnt},
          32'd0);

    // RST mid-acquire: acquisition starts over.
    comma(); comma();
    step(1'b1, 1'b1, 1'b1, 8'hBC, 1'b0);
    check("rstacq_outs", {29'd0, slip, sync, dvo}, 32'd0);
    comma();
    check("rstacq_sync", {31'd0, sync}, 32'd0);

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(99));
      rr = ($urandom_range(499) == 0);
      dv = ($urandom_range(9) != 0);
      vi = ($urandom_range(99) < 7);
      if (r < 40) begin
        kk = 1'b1;
        dd = 8'hBC;
      end else begin
        kk = ($urandom_range(9) == 0);
        dd = 8'($urandom);
      end
      step(rr, dv, kk, dd, vi);
      check($sformatf("rand%0d", i),
            {3'd0, slip, sync, dvo, k_o, do_o, viol_o, err_cnt},
            {3'd0, m_slip, m_sync, m_dvo, m_k, m_do, m_viol, 16'(m_err)});
    end

    // ERR_CNT saturation on the tolerant instance.
    s_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    sent = 0;
    while (sent < 65535) begin
      s_step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b0);
      s_step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < 1000 && sent < 65535; i++) begin
        s_step(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
        sent++;
      end
      if (sent == 1000) begin
        check("sat_first_loss", {31'd0, s_sync}, 32'd0);
        check("sat_first_cnt", {16'd0, s_err}, 32'd1000);
      end
    end
    check("sat_insync", {31'd0, s_sync}, 32'd1);
    check("sat_full", {16'd0, s_err}, 32'hFFFF);
    s_step(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
    check("sat_hold", {16'd0, s_err}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
